inv_shiftrow_bytesub: RTL and testbench



---
 rtl/aes_dec_pkg.sv | 42 ++++
 rtl/inv_sbox_rom.sv | 11 +
 rtl/inv_shiftrow_bytesub.sv | 127 ++++++++++++
 tb/tb_inv_shiftrow_bytesub.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decrypt round stages: FSM states, sizes,
// the inverse S-box table and the statemt address mapping.
package aes_dec_pkg;

   localparam int STATE_AW = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_ROWS = 4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_A = 3'd1,
      RD_B = 3'd2,
      CAP  = 3'd3,
      WR_A = 3'd4,
      WR_B = 3'd5
   } state_t;

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Column-major state layout: byte (r,c) lives at r + 4c.
   function automatic logic [STATE_AW-1:0] addr(input logic [1:0] r, input logic [1:0] c);
      return {1'b0, c, r};
   endfunction

endpackage

// File: rtl/inv_sbox_rom.sv
// Combinational inverse S-box lookup on the shared table.
module inv_sbox_rom
   import aes_dec_pkg::*;
(
   input  logic [7:0] din,
   output logic [7:0] dout
);

   assign dout = INV_SBOX[din];

endmodule

// File: rtl/inv_shiftrow_bytesub.sv
// InvShiftRows + InvSubBytes applied in place to statemt, one row per 5 cycles.
//   state | meaning
//   IDLE  | waiting for ap_start
//   RD_A  | read columns 0,1 of current row
//   RD_B  | read columns 2,3; capture columns 0,1
//   CAP   | capture columns 2,3
//   WR_A  | write columns 0,1 (shifted, inverse-substituted)
//   WR_B  | write columns 2,3; done on last row
module inv_shiftrow_bytesub
   import aes_dec_pkg::*;
(
   input  logic                ap_clk,
   input  logic                ap_rst,
   input  logic                ap_start,
   output logic                ap_done,
   output logic                ap_idle,
   output logic                ap_ready,
   output logic [STATE_AW-1:0] statemt_address0,
   output logic                statemt_ce0,
   output logic                statemt_we0,
   output logic [DATA_W-1:0]   statemt_d0,
   input  logic [DATA_W-1:0]   statemt_q0,
   output logic [STATE_AW-1:0] statemt_address1,
   output logic                statemt_ce1,
   output logic                statemt_we1,
   output logic [DATA_W-1:0]   statemt_d1,
   input  logic [DATA_W-1:0]   statemt_q1
);

   state_t     state, state_nxt;
   logic [1:0] row;
   logic [7:0] byte_buf [4];
   logic [1:0] col_base;
   logic [1:0] col_odd;
   logic [1:0] src0, src1;
   logic [7:0] sbox_out0, sbox_out1;
   logic       unused_q;

   assign unused_q = ^{statemt_q0[DATA_W-1:8], statemt_q1[DATA_W-1:8]};

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state <= IDLE;
         row   <= 2'd0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && ap_start)
            row <= 2'd0;
         else if (state == WR_B && row != 2'd3)
            row <= row + 2'd1;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (state == RD_B) begin
         byte_buf[0] <= statemt_q0[7:0];
         byte_buf[1] <= statemt_q1[7:0];
      end else if (state == CAP) begin
         byte_buf[2] <= statemt_q0[7:0];
         byte_buf[3] <= statemt_q1[7:0];
      end
   end

   // Columns handled this cycle are col_base and col_base+1; the source
   // column for the shifted write wraps naturally in 2-bit arithmetic.
   assign col_odd = col_base | 2'd1;
   assign src0    = col_base - row;
   assign src1    = col_odd - row;

   inv_sbox_rom u_sbox0 (.din(byte_buf[src0]), .dout(sbox_out0));
   inv_sbox_rom u_sbox1 (.din(byte_buf[src1]), .dout(sbox_out1));

   assign statemt_d0 = {{(DATA_W-8){1'b0}}, sbox_out0};
   assign statemt_d1 = {{(DATA_W-8){1'b0}}, sbox_out1};
   assign statemt_address0 = addr(row, col_base);
   assign statemt_address1 = addr(row, col_odd);
   assign ap_idle = (state == IDLE) && !ap_start;

   always_comb begin
      state_nxt   = state;
      col_base    = 2'd0;
      ap_done     = 1'b0;
      ap_ready    = 1'b0;
      statemt_ce0 = 1'b0;
      statemt_we0 = 1'b0;
      statemt_ce1 = 1'b0;
      statemt_we1 = 1'b0;
      case (state)
         IDLE: if (ap_start) state_nxt = RD_A;
         RD_A: begin
            statemt_ce0 = 1'b1;
            statemt_ce1 = 1'b1;
            state_nxt   = RD_B;
         end
         RD_B: begin
            statemt_ce0 = 1'b1;
            statemt_ce1 = 1'b1;
            col_base    = 2'd2;
            state_nxt   = CAP;
         end
         CAP: state_nxt = WR_A;
         WR_A: begin
            statemt_ce0 = 1'b1;
            statemt_we0 = 1'b1;
            statemt_ce1 = 1'b1;
            statemt_we1 = 1'b1;
            state_nxt   = WR_B;
         end
         WR_B: begin
            statemt_ce0 = 1'b1;
            statemt_we0 = 1'b1;
            statemt_ce1 = 1'b1;
            statemt_we1 = 1'b1;
            col_base    = 2'd2;
            if (row == 2'd3) begin
               ap_done   = 1'b1;
               ap_ready  = 1'b1;
               state_nxt = IDLE;
            end else begin
               state_nxt = RD_A;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_inv_shiftrow_bytesub.sv
// Bench for inv_shiftrow_bytesub: statemt memory model plus a reference built
// from GF(2^8) arithmetic (S-box derived, then inverted) and the row-shift rule.
module tb_inv_shiftrow_bytesub;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic        ap_start;
   logic        ap_done, ap_idle, ap_ready;
   logic [4:0]  statemt_address0, statemt_address1;
   logic        statemt_ce0, statemt_we0, statemt_ce1, statemt_we1;
   logic [31:0] statemt_d0, statemt_d1;
   logic [31:0] statemt_q0, statemt_q1;

   logic [31:0] mem     [32];
   logic [31:0] exp_mem [32];
   logic [7:0]  sbox    [256];
   logic [7:0]  inv_sb  [256];
   int          errors = 0;
   int          checks = 0;

   always #5 ap_clk = ~ap_clk;

   inv_shiftrow_bytesub dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
      .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .statemt_address0(statemt_address0), .statemt_ce0(statemt_ce0),
      .statemt_we0(statemt_we0), .statemt_d0(statemt_d0), .statemt_q0(statemt_q0),
      .statemt_address1(statemt_address1), .statemt_ce1(statemt_ce1),
      .statemt_we1(statemt_we1), .statemt_d1(statemt_d1), .statemt_q1(statemt_q1)
   );

   // Dual-port RAM, 1-cycle read latency
   always @(posedge ap_clk) begin
      if (statemt_ce0 && !statemt_we0) statemt_q0 <= mem[statemt_address0];
      if (statemt_ce1 && !statemt_we1) statemt_q1 <= mem[statemt_address1];
      if (statemt_ce0 && statemt_we0) mem[statemt_address0] = statemt_d0;
      if (statemt_ce1 && statemt_we1) mem[statemt_address1] = statemt_d1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   task automatic build_tables();
      logic [7:0] b, s;
      for (int v = 0; v < 256; v++) begin
         b = 8'h00;
         for (int w = 1; w < 256; w++)
            if (v != 0 && gmul(8'(v), 8'(w)) == 8'h01) b = 8'(w);
         s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
         sbox[v] = s;
      end
      for (int v = 0; v < 256; v++) inv_sb[sbox[v]] = 8'(v);
   endtask

   // Apply the transform to the first nrows rows of exp_mem.
   task automatic model_apply(input int nrows);
      logic [31:0] old [32];
      old = exp_mem;
      for (int r = 0; r < nrows; r++)
         for (int c = 0; c < 4; c++)
            exp_mem[r + 4*c] = {24'd0, inv_sb[old[r + 4*((c - r + 4) % 4)][7:0]]};
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < 32; i++)
         check($sformatf("%s_m%0d", tag, i), mem[i], exp_mem[i]);
   endtask

   task automatic run_check(input string tag, input bit toggle);
      int k;
      bit seen;
      @(negedge ap_clk);
      ap_start = 1'b1;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 60) begin
         @(negedge ap_clk);
         k++;
         if (toggle && k < 18) ap_start = 1'($urandom_range(0, 1));
         else                  ap_start = 1'b0;
         if (ap_done) begin
            seen = 1'b1;
            check({tag, "_ready"}, 32'(ap_ready), 32'd1);
         end
      end
      check({tag, "_latency"}, 32'(k), 32'd20);
      @(negedge ap_clk);
      check({tag, "_idle_after"}, {ap_idle, ap_done, statemt_ce0, statemt_ce1}, 32'b1000);
      check_mem(tag);
   endtask

   initial begin
      int k, dones, d1, d2;
      ap_rst = 1'b1;
      ap_start = 1'b0;
      build_tables();
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      repeat (3) @(negedge ap_clk);
      ap_rst = 1'b0;
      #1;
      check("rst_idle", {ap_idle, ap_done, ap_ready}, 32'b100);
      check("rst_mem_en", {statemt_ce0, statemt_we0, statemt_ce1, statemt_we1}, 32'b0000);

      // All 0x63 -> all zero
      for (int i = 0; i < 16; i++) mem[i] = 32'h00000063;
      exp_mem = mem; model_apply(4);
      run_check("all63", 1'b0);

      // Forward S-box of the index
      for (int i = 0; i < 16; i++) mem[i] = {24'd0, sbox[i]};
      exp_mem = mem; model_apply(4);
      run_check("sbox_idx", 1'b0);
      check("sbox_idx_e1", mem[1], 32'h0000000d);
      check("sbox_idx_e5", mem[5], 32'h00000001);
      check("sbox_idx_e15", mem[15], 32'h00000003);

      // Upper bits must be cleared
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      mem[0] = 32'hFFFFFF63;
      exp_mem = mem; model_apply(4);
      run_check("upper", 1'b0);
      check("upper_e0", mem[0], 32'h00000000);

      // Random contents, some runs with ap_start toggled mid-operation
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 32; i++) mem[i] = $urandom;
         exp_mem = mem; model_apply(4);
         run_check($sformatf("rand%0d", n), 1'(n & 1));
      end

      // Reset in WR_A of row 1: only row 0 updated, no done
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      exp_mem = mem; model_apply(1);
      @(negedge ap_clk);
      ap_start = 1'b1;
      k = 0; dones = 0;
      while (k < 9) begin
         @(negedge ap_clk);
         k++;
         ap_start = 1'b0;
         if (ap_done) dones++;
      end
      check("midrst_in_wr", {statemt_we0, statemt_we1}, 32'b11);
      ap_rst = 1'b1;
      #1;
      check("midrst_idle", {ap_idle, ap_done, statemt_ce0, statemt_ce1}, 32'b1000);
      repeat (2) @(negedge ap_clk);
      ap_rst = 1'b0;
      check("midrst_dones", 32'(dones), 32'd0);
      check_mem("midrst");
      exp_mem = mem; model_apply(4);
      run_check("after_rst", 1'b0);

      // ap_start held high: back-to-back runs
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      exp_mem = mem; model_apply(4); model_apply(4);
      @(negedge ap_clk);
      ap_start = 1'b1;
      k = 0; d1 = 0; d2 = 0;
      while (d2 == 0 && k < 100) begin
         @(negedge ap_clk);
         k++;
         if (k == 21) check("held_idle_gap", 32'(ap_idle), 32'd0);
         if (k == 22) ap_start = 1'b0;
         if (ap_done) begin
            if (d1 == 0) d1 = k;
            else         d2 = k;
         end
      end
      check("held_done1", 32'(d1), 32'd20);
      check("held_done2", 32'(d2), 32'd41);
      @(negedge ap_clk);
      check("held_idle_end", 32'(ap_idle), 32'd1);
      check_mem("held");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
